// File: rtl/md_pad_responder.sv
// Mega Drive pad emulation: tracks SELECT strobes and drives the active-low 6-bit pad data bus.
// Define MD_PAD_SIX_BUTTON_EN for the 6-button protocol; otherwise a plain 3-button pad is presented.
module md_pad_responder #(
  parameter int TIMEOUT_CYCLES = 150000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk_peripheral,
  input  logic        reset_n,
  input  logic [10:0] joystick,
  input  logic        md_select,
  output logic [5:0]  md_data
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [10:0]            joy_q;
  logic [5:0]             md_data_q;
  logic [5:0]             md_data_d;
  logic [2:0]             n_q;
  logic                   sel_s;

  // Idle SELECT level is high, so the chain resets to 1 to avoid a false fall.
  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      joy_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], md_select};
      joy_q  <= joystick;
    end
  end

  assign sel_s = sync_q[SYNC_STAGES-1];

`ifdef MD_PAD_SIX_BUTTON_EN
  localparam int              TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TPRE = TW'(TIMEOUT_CYCLES - 1);

  logic          sel_prev_q;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic [2:0]    n_d;
  logic          fall;
  logic          expire;

  assign fall   = sel_prev_q & ~sel_s;
  // The timer reaches TIMEOUT_CYCLES on this edge; a coincident fall still counts as strobe one.
  assign expire = (timer_q == TPRE);

  always_comb begin
    timer_d = timer_q;
    n_d     = n_q;
    if (fall) begin
      timer_d = '0;
      if (expire)
        n_d = 3'd1;
      else if (n_q >= 3'd4)
        n_d = 3'd4;
      else
        n_d = n_q + 3'd1;
    end else begin
      if (timer_q != TMAX)
        timer_d = timer_q + TW'(1);
      if (expire)
        n_d = 3'd0;
    end
  end

  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      sel_prev_q <= 1'b1;
      timer_q    <= '0;
      n_q        <= 3'd0;
    end else begin
      sel_prev_q <= sel_s;
      timer_q    <= timer_d;
      n_q        <= n_d;
    end
  end
`else
  assign n_q = 3'd0;
`endif

  // Joystick word: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]START [8]X [9]Y [10]Z.
  always_comb begin
    md_data_d = 6'b111111;
    if (sel_s) begin
      if (n_q == 3'd3)
        md_data_d = ~{joy_q[5], joy_q[4], 1'b0, joy_q[8], joy_q[9], joy_q[10]};
      else
        md_data_d = ~{joy_q[5], joy_q[4], joy_q[0], joy_q[1], joy_q[2], joy_q[3]};
    end else begin
      if (n_q == 3'd3)
        md_data_d = {~joy_q[7], ~joy_q[6], 4'b0000};
      else if (n_q >= 3'd4)
        md_data_d = {~joy_q[7], ~joy_q[6], 4'b1111};
      else
        md_data_d = {~joy_q[7], ~joy_q[6], 2'b00, ~joy_q[2], ~joy_q[3]};
    end
  end

  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n)
      md_data_q <= 6'b111111;
    else
      md_data_q <= md_data_d;
  end

  assign md_data = md_data_q;

endmodule

// File: tb/tb_md_pad_responder.sv
// Bench for md_pad_responder: reference pad model compared every cycle, plus pinned literal rows.
module tb_md_pad_responder;
  localparam int T  = 24;
  localparam int SS = 3;
`ifdef MD_PAD_SIX_BUTTON_EN
  localparam bit SIX = 1'b1;
`else
  localparam bit SIX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] joy = '0;
  logic        sel = 1'b1;
  logic [5:0]  md;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  md_pad_responder #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(SS)) dut (
    .clk_peripheral(clk),
    .reset_n       (rst_n),
    .joystick      (joy),
    .md_select     (sel),
    .md_data       (md)
  );

  // Pad output for a given SELECT level, strobe count and button word, straight from the row table.
  function automatic logic [5:0] pad_row(input logic s, input int n_in, input logic [10:0] j);
    int n;
    logic r, l, d, u, b, c, a, st, x, y, z;
    n  = SIX ? n_in : 0;
    r  = j[0]; l = j[1]; d = j[2]; u = j[3]; b = j[4]; c = j[5];
    a  = j[6]; st = j[7]; x = j[8]; y = j[9]; z = j[10];
    if (s && n != 3) return ~{c, b, r, l, d, u};
    if (s)           return ~{c, b, 1'b0, x, y, z};
    if (n < 3)       return {~st, ~a, 2'b00, ~d, ~u};
    if (n == 3)      return {~st, ~a, 4'b0000};
    return {~st, ~a, 4'b1111};
  endfunction

  // Reference state: delayed copies of the inputs, strobe count and cycles since last fall.
  logic [SS-1:0] pipe_m = '1;
  logic          prev_m = 1'b1;
  logic [10:0]   j_m = '0;
  int            n_m = 0;
  int            idle_m = 0;
  logic [5:0]    exp_m = 6'h3F;

  always @(posedge clk) begin : model
    logic s;
    int   nn, ii;
    if (!rst_n) begin
      pipe_m <= '1;
      prev_m <= 1'b1;
      j_m    <= '0;
      n_m    <= 0;
      idle_m <= 0;
      exp_m  <= 6'h3F;
    end else begin
      s  = pipe_m[SS-1];
      nn = n_m;
      ii = idle_m;
      exp_m <= pad_row(s, n_m, j_m);
      if (prev_m && !s) begin
        // A fall landing on the T-th idle cycle starts a fresh sequence.
        if (ii + 1 >= T) nn = 1;
        else nn = (nn < 4) ? nn + 1 : 4;
        ii = 0;
      end else begin
        if (ii < T) ii = ii + 1;
        if (ii >= T) nn = 0;
      end
      n_m    <= nn;
      idle_m <= ii;
      prev_m <= s;
      pipe_m <= {pipe_m[SS-2:0], sel};
      j_m    <= joy;
    end
  end

  always @(negedge clk) begin : compare
    logic [5:0] e;
    e = rst_n ? exp_m : 6'h3F;
    checks = checks + 1;
    if (md !== e) begin
      errors = errors + 1;
      $display("FAIL cycle_cmp t=%0t md_data=%b expected=%b", $time, md, e);
    end
  end

  task automatic pin(input string name, input logic [5:0] e);
    checks = checks + 1;
    if (md !== e) begin
      errors = errors + 1;
      $display("FAIL %s md_data=%b expected=%b", name, md, e);
    end else begin
      $display("ok   %s md_data=%b", name, md);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    int r, hold;
    // Reset and release
    rst_n = 1'b0; joy = 11'h7FF; sel = 1'b1;
    tick(3);
    pin("reset_hold", 6'b111111);
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    pin("release_edge1", 6'b111111);
    tick(1);
    pin("release_edge2", 6'b000000);

    // R and U pressed, SELECT latency
    joy = 11'h009;
    tick(2);
    pin("ru_sel_high", 6'b110110);
    sel = 1'b0;
    tick(SS);
    pin("sel_latency_pre", 6'b110110);
    tick(1);
    pin("sel_latency", 6'b110010);

    // Let the count time out, then strobe X/Z pattern
    sel = 1'b1;
    tick(T + 8);
    joy = 11'h500;
    sel = 1'b0; tick(5); sel = 1'b1; tick(5);
    sel = 1'b0; tick(5); sel = 1'b1; tick(5);
    sel = 1'b0; tick(SS + 3);
    pin("third_fall_low", SIX ? 6'b110000 : 6'b110011);
    sel = 1'b1; tick(SS + 2);
    pin("third_fall_high", SIX ? 6'b111010 : 6'b111111);
    sel = 1'b0; tick(SS + 3);
    pin("fourth_fall", SIX ? 6'b111111 : 6'b110011);

    // Saturated count holds until the idle timeout, then clears
    tick(T - 8);
    pin("pre_timeout", SIX ? 6'b111111 : 6'b110011);
    tick(12);
    pin("post_timeout", 6'b110011);

    // Fall exactly on the timeout cycle counts as the first strobe
    joy = 11'h0C0;
    sel = 1'b1; tick(T + 8);
    sel = 1'b0; tick(2); sel = 1'b1; tick(T - 2);
    sel = 1'b0; tick(2); sel = 1'b1; tick(4);
    sel = 1'b0; tick(2); sel = 1'b1; tick(4);
    sel = 1'b0; tick(SS + 3);
    pin("coincident_fall", SIX ? 6'b000000 : 6'b000011);

    // Asynchronous reset mid-sequence
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 pin("async_reset", 6'b111111);
    tick(3);
    @(negedge clk) rst_n = 1'b1;
    tick(SS + 4);

    // Randomized strobing and buttons
    for (int i = 0; i < 400; i++) begin
      joy = 11'($urandom);
      sel = ~sel;
      r = $urandom_range(0, 9);
      if (r < 6)      hold = $urandom_range(1, 6);
      else if (r < 9) hold = $urandom_range(7, 14);
      else            hold = $urandom_range(T - 2, T + 4);
      tick(hold);
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
    end
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
